// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS harness: reset hold, halt/timeout detection, GRF trace FIFO.
// Optional TRACE_SKIP_ZERO_EN: writes to $0 are neither traced nor counted.
module mips_run_ctrl #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SPIN_LIMIT = 16,
  parameter int unsigned MAX_CYCLES = 10000,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             core_reset,
  input  logic [31:0]      cur_pc,
  input  logic             wb_valid,
  input  logic [31:0]      wb_pc,
  input  logic [4:0]       wb_addr,
  input  logic [31:0]      wb_data,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [31:0]      trc_pc,
  output logic [4:0]       trc_addr,
  output logic [31:0]      trc_data,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             done,
  output logic             timeout,
  output logic             overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam int SW = $clog2(SPIN_LIMIT + 1);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } rec_t;

  state_e         state_q, state_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [SW-1:0]  spin_q, spin_d;
  logic [31:0]    prev_pc_q;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic           tmo_q, tmo_d;
  logic           ovf_q, ovf_d;
  logic [AW:0]    wptr_q, wptr_d;
  logic [AW:0]    rptr_q, rptr_d;
  rec_t           mem_q [FIFO_DEPTH];

  logic           empty;
  logic           full;
  logic           pop;
  logic           push_base;
  logic           push_req;
  logic           push;
  logic [SW-1:0]  spin_nxt;
  logic           halt;
  logic           hold_last;
  logic           cyc_last;
  logic [CNT_W-1:0] cyc_inc;
  rec_t           head;
  rec_t           wrec;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && trc_ready;

  assign push_base = wb_valid && (state_q == S_RUN);
`ifdef TRACE_SKIP_ZERO_EN
  assign push_req = push_base && (wb_addr != 5'd0);
`else
  assign push_req = push_base;
`endif
  // A full FIFO still accepts when the head leaves on the same edge.
  assign push = push_req && (!full || pop);

  assign wptr_d = wptr_q + {{AW{1'b0}}, push};
  assign rptr_d = rptr_q + {{AW{1'b0}}, pop};

  assign spin_nxt  = (cur_pc == prev_pc_q) ? spin_q + 1'b1 : '0;
  assign halt      = (spin_nxt == SW'(SPIN_LIMIT - 1));
  assign hold_last = (hold_q == HW'(RST_CYCLES - 1));
  assign cyc_last  = (cyc_q == CNT_W'(MAX_CYCLES - 1));
  assign cyc_inc   = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

  assign wrec.pc   = wb_pc;
  assign wrec.addr = wb_addr;
  assign wrec.data = wb_data;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    spin_d     = '0;
    cyc_d      = cyc_q;
    ret_d      = ret_q;
    tmo_d      = tmo_q;
    ovf_d      = ovf_q;
    core_reset = 1'b1;
    done       = 1'b0;
    if (push) ret_d = ret_q + 1'b1;
    if (push_req && full && !pop) ovf_d = 1'b1;
    unique case (state_q)
      S_HOLD: begin
        if (hold_last) begin
          state_d = S_RUN;
          hold_d  = '0;
          cyc_d   = cyc_inc;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_RUN: begin
        core_reset = 1'b0;
        cyc_d      = cyc_inc;
        spin_d     = spin_nxt;
        // Halt has priority over a coincident timeout.
        if (halt) begin
          state_d = S_DRAIN;
        end else if (cyc_last) begin
          state_d = S_DRAIN;
          tmo_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (empty) state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HOLD;
      hold_q    <= '0;
      spin_q    <= '0;
      prev_pc_q <= '0;
      cyc_q     <= '0;
      ret_q     <= '0;
      tmo_q     <= 1'b0;
      ovf_q     <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      spin_q    <= spin_d;
      prev_pc_q <= cur_pc;
      cyc_q     <= cyc_d;
      ret_q     <= ret_d;
      tmo_q     <= tmo_d;
      ovf_q     <= ovf_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wrec;
  end

  assign head      = mem_q[rptr_q[AW-1:0]];
  assign trc_valid = !empty;
  assign trc_pc    = empty ? 32'd0 : head.pc;
  assign trc_addr  = empty ? 5'd0  : head.addr;
  assign trc_data  = empty ? 32'd0 : head.data;

  assign cycle_cnt  = cyc_q;
  assign retire_cnt = ret_q;
  assign timeout    = tmo_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: reset hold, halt, trace order, overflow, timeout.
module tb_mips_run_ctrl;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        core_reset;
  logic [31:0] cur_pc;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        trc_valid;
  logic        trc_ready;
  logic [31:0] trc_pc;
  logic [4:0]  trc_addr;
  logic [31:0] trc_data;
  logic [31:0] cycle_cnt;
  logic [31:0] retire_cnt;
  logic        done;
  logic        timeout;
  logic        overflow;

  logic [68:0] sbq [$];
  int ncmp = 0;
  int nfail = 0;
  int exp_ret = 0;
  bit exp_ovf = 0;

  mips_run_ctrl #(
    .RST_CYCLES(4),
    .FIFO_DEPTH(DEPTH),
    .SPIN_LIMIT(16),
    .MAX_CYCLES(100),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_reset(core_reset),
    .cur_pc(cur_pc),
    .wb_valid(wb_valid),
    .wb_pc(wb_pc),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .trc_valid(trc_valid),
    .trc_ready(trc_ready),
    .trc_pc(trc_pc),
    .trc_addr(trc_addr),
    .trc_data(trc_data),
    .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt),
    .done(done),
    .timeout(timeout),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already set for the coming edge.
  task automatic step();
    logic [68:0] e;
    bit take;
    chk("trc_valid", {31'd0, trc_valid}, {31'd0, sbq.size() != 0});
    if (sbq.size() != 0 && trc_ready) begin
      e = sbq.pop_front();
      chk("trc_pc", trc_pc, e[68:37]);
      chk("trc_addr", {27'd0, trc_addr}, {27'd0, e[36:32]});
      chk("trc_data", trc_data, e[31:0]);
    end
    take = wb_valid;
`ifdef TRACE_SKIP_ZERO_EN
    if (wb_addr == 5'd0) take = 1'b0;
`endif
    if (take) begin
      if (sbq.size() < DEPTH) begin
        sbq.push_back({wb_pc, wb_addr, wb_data});
        exp_ret++;
      end else begin
        exp_ovf = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic restart();
    reset     = 1'b1;
    wb_valid  = 1'b0;
    trc_ready = 1'b0;
    cur_pc    = 32'd0;
    wb_pc     = 32'd0;
    wb_addr   = 5'd0;
    wb_data   = 32'd0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
    chk("rst_trc_valid", {31'd0, trc_valid}, 32'd0);
    chk("rst_trc_pc", trc_pc, 32'd0);
    chk("rst_trc_addr", {27'd0, trc_addr}, 32'd0);
    chk("rst_trc_data", trc_data, 32'd0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("rst_retire_cnt", retire_cnt, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    sbq.delete();
    exp_ret = 0;
    exp_ovf = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_core_reset", {31'd0, core_reset}, 32'd1);
      step();
    end
    chk("run_core_reset", {31'd0, core_reset}, 32'd0);
    chk("run_first_cycle_cnt", cycle_cnt, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    wb_valid  = 1'b0;
    trc_ready = 1'b0;
    cur_pc    = 32'd0;
    wb_pc     = 32'd0;
    wb_addr   = 5'd0;
    wb_data   = 32'd0;

    // Trace ordering, then halt on a spinning PC.
    restart();
    trc_ready = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      cur_pc   = 32'h3000 + 32'(4 * n);
      wb_valid = (n >= 2 && n <= 4);
      wb_pc    = cur_pc;
      wb_addr  = (n == 3) ? 5'd9 : 5'd8;
      wb_data  = 32'(n - 1);
      step();
    end
    wb_valid = 1'b0;
    chk("order_retire_cnt", retire_cnt, 32'd3);
    for (int k = 0; k < 16; k++) begin
      cur_pc = 32'h0000_3010;
      chk("spin_core_reset", {31'd0, core_reset}, 32'd0);
      step();
    end
    chk("drain_core_reset", {31'd0, core_reset}, 32'd1);
    chk("drain_done", {31'd0, done}, 32'd0);
    chk("halt_cycle_cnt", cycle_cnt, 32'd36);
    step();
    chk("halt_done", {31'd0, done}, 32'd1);
    chk("halt_timeout", {31'd0, timeout}, 32'd0);
    chk("halt_cycle_hold", cycle_cnt, 32'd36);
    chk("halt_retire_cnt", retire_cnt, 32'd3);

    // Overflow with a stalled logger, then drain after halt.
    restart();
    trc_ready = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      cur_pc   = 32'h4000 + 32'(4 * n);
      wb_valid = 1'b1;
      wb_pc    = cur_pc;
      wb_addr  = 5'(n);
      wb_data  = 32'(n * 17);
      step();
    end
    wb_valid = 1'b0;
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_retire_cnt", retire_cnt, 32'd8);
    trc_ready = 1'b1;
    cur_pc    = 32'h0000_4100;
    for (int i = 0; i < 40 && done !== 1'b1; i++) step();
    chk("ovf_done", {31'd0, done}, 32'd1);
    chk("ovf_cycle_cnt", cycle_cnt, 32'd27);
    chk("ovf_retire_hold", retire_cnt, 32'd8);
    chk("ovf_empty", {31'd0, trc_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Timeout with a PC that never repeats; $0 and $1 writes.
    restart();
    trc_ready = 1'b1;
    for (int n = 1; n <= 99; n++) begin
      cur_pc   = 32'h5000 + 32'(4 * n);
      wb_valid = (n == 5 || n == 6);
      wb_pc    = cur_pc;
      wb_addr  = (n == 5) ? 5'd0 : 5'd1;
      wb_data  = (n == 5) ? 32'd5 : 32'd6;
      step();
    end
    wb_valid = 1'b0;
    chk("tmo_core_reset", {31'd0, core_reset}, 32'd1);
    chk("tmo_flag", {31'd0, timeout}, 32'd1);
    chk("tmo_cycle_cnt", cycle_cnt, 32'd100);
    step();
    chk("tmo_done", {31'd0, done}, 32'd1);
    chk("tmo_retire_model", retire_cnt, 32'(exp_ret));
`ifdef TRACE_SKIP_ZERO_EN
    chk("tmo_retire_cnt", retire_cnt, 32'd1);
`else
    chk("tmo_retire_cnt", retire_cnt, 32'd2);
`endif
    chk("tmo_overflow", {31'd0, overflow}, 32'd0);
    chk("tmo_cycle_hold", cycle_cnt, 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Synthesizable run controller for the pipelined MIPS core harness. Replaces the fixed free-running clock/reset stimulus.
- Holds the core in reset for a configurable number of cycles, then releases it and counts cycles and retired GRF writes.
- Buffers each register-file write as a trace record in a FIFO. A logger drains the FIFO through a valid/ready handshake.
- Ends the run on a PC-spin (halt loop) or a cycle timeout, drains the FIFO, then reports done.

Parameters:
RST_CYCLES, 4, cycles core_reset stays high after reset deasserts (>=1)
FIFO_DEPTH, 8, trace FIFO entries (power of two, >=2)
SPIN_LIMIT, 16, consecutive cycles with unchanged cur_pc that declare a halt (>=2)
MAX_CYCLES, 10000, RUN-state cycle budget before timeout
CNT_W, 32, width of cycle_cnt and retire_cnt

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous active-high reset
core_reset  output  1  reset driven to the core under test
cur_pc  input  32  core fetch-stage PC
wb_valid  input  1  GRF write retiring this cycle
wb_pc  input  32  PC of the retiring instruction
wb_addr  input  5  GRF destination register
wb_data  input  32  GRF write data
trc_valid  output  1  trace record available
trc_ready  input  1  logger accepts record
trc_pc  output  32  record PC
trc_addr  output  5  record register
trc_data  output  32  record data
cycle_cnt  output  CNT_W  cycles spent in RUN
retire_cnt  output  CNT_W  trace records accepted into the FIFO
done  output  1  run finished and FIFO drained
timeout  output  1  run ended by MAX_CYCLES (sticky)
overflow  output  1  record dropped because the FIFO was full (sticky)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset. All state updates on the rising edge of clk.
- Reset values:
  - core_reset=1.
  - trc_valid=0, trc_pc/trc_addr/trc_data=0.
  - cycle_cnt=0, retire_cnt=0.
  - done=0, timeout=0, overflow=0.
  - FIFO empty, FSM in HOLD, hold counter 0.
- FSM states: HOLD, RUN, DRAIN, DONE.
  - HOLD: core_reset=1; hold counter increments each cycle. When the counter reaches RST_CYCLES-1, the next state is RUN. core_reset is therefore high for exactly RST_CYCLES cycles after reset falls.
  - RUN: core_reset=0; cycle_cnt increments every cycle, saturating at all-ones.
    - Spin counter: resets to 0 when cur_pc differs from last cycle's cur_pc, otherwise increments.
    - Halt: spin counter reaches SPIN_LIMIT-1 -> DRAIN.
    - Timeout: cycle_cnt reaches MAX_CYCLES-1 -> DRAIN with timeout set.
    - If halt and timeout fire in the same cycle, halt wins and timeout stays 0.
  - DRAIN: core_reset=1 to freeze the core. wb_valid is ignored. Next state is DONE in the cycle after the FIFO becomes empty.
  - DONE: done=1. The FSM stays here until reset.
- Trace FIFO:
  - Write: wb_valid in RUN writes {wb_pc, wb_addr, wb_data}.
  - Read: a record pops when trc_valid && trc_ready. trc_valid = FIFO not empty; trc_* show the head entry combinationally from storage.
  - Full FIFO: if it is full and no pop happens the same cycle, the write is dropped, overflow is set, and retire_cnt is unchanged.
  - Full plus simultaneous pop: push and pop both succeed, and the occupancy stays the same.
  - Empty plus simultaneous push: the record appears on trc_* the next cycle. There is no fall-through.
  - Pointers are log2(FIFO_DEPTH) bits plus a wrap bit, and wrap modulo the depth.
  - retire_cnt increments once per accepted write.
- Held values after RUN: cycle_cnt and retire_cnt hold their values in DRAIN and DONE.
- Reset mid-run: reset in any state returns everything to reset values the next edge. The FIFO contents are discarded.
- Logger stalls: trc_ready low for any duration only delays DRAIN -> DONE. There is no timeout in DRAIN.

Optional Feature:
- Macro: TRACE_SKIP_ZERO_EN.
- When defined: writes with wb_addr==0 are not pushed. They do not count toward retire_cnt and cannot cause overflow. This mirrors the fact that the $0 register ignores writes.
- When undefined: every wb_valid in RUN is pushed and counted, including writes with wb_addr==0.

Test Plan:
- Reset release with RST_CYCLES=4 -> core_reset high 4 cycles after reset falls, then low; cycle_cnt=1 on the first RUN cycle after the transition edge.
- Halt detect: cur_pc constant at 0x00003010 from RUN cycle 20, SPIN_LIMIT=16 -> DRAIN entered after 16 equal-PC cycles; FIFO empty -> done=1 one cycle later, timeout=0.
- Trace ordering: 3 writes ($8=0x1, $9=0x2, $8=0x3), trc_ready=1 -> records emerge in order one cycle after each push; retire_cnt=3.
- Overflow: FIFO_DEPTH=8, trc_ready=0, 10 consecutive writes -> 8 accepted, overflow=1, retire_cnt=8.
- Overflow (continued): then halt with trc_ready=1 -> 8 records drained in order, then done=1.
- Timeout: MAX_CYCLES=100, cur_pc changing every cycle -> timeout=1, cycle_cnt=100, done=1 after drain.
- TRACE_SKIP_ZERO_EN: write $0=0x5 then $1=0x6 -> only the $1 record is emitted, retire_cnt=1. Without the macro, both records are emitted and retire_cnt=2.
